mem_ctrl: RTL and testbench

Byte-serial memory controller and arbiter between the core and the 8-bit RAM/IO bus. It is the responder for the load/store buffer's query/reply handshake and for instruction-cache word fetches. It splits each 1/2/4-byte access into single-byte RAM cycles, assembles little-endian read data, and returns a one-cycle reply pulse. It sits between the execute/fetch units and the external `mem_*` pins.

---
 rtl/mem_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO bus controller: arbitrates LSB and icache requests,
// splits 1/2/4-byte accesses into single-byte bus cycles and returns reply pulses.
module mem_ctrl #(
  parameter logic [31:0] IO_ADDR = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_signal,
  input  logic        lsb_query_en,
  input  logic        lsb_query_type,
  input  logic [31:0] lsb_query_addr,
  input  logic [1:0]  lsb_data_width,
  input  logic [31:0] lsb_query_data,
  output logic        lsb_reply_en,
  output logic [31:0] lsb_reply_data,
  input  logic        ic_query_en,
  input  logic [31:0] ic_query_addr,
  output logic        ic_reply_en,
  output logic [31:0] ic_reply_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, COOL} state_t;

  localparam logic OWN_LSB = 1'b0;
  localparam logic OWN_IC  = 1'b1;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic [2:0]  n_reg, n_next;
  logic [2:0]  k_reg, k_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic [31:0] buf_reg, buf_next;
  logic [31:0] mem_a_reg, mem_a_next;
  logic [7:0]  mem_dout_reg, mem_dout_next;
  logic        mem_wr_reg, mem_wr_next;
  logic        lsb_reply_en_reg, lsb_reply_en_next;
  logic [31:0] lsb_reply_data_reg, lsb_reply_data_next;
  logic        ic_reply_en_reg, ic_reply_en_next;
  logic [31:0] ic_reply_data_reg, ic_reply_data_next;

  logic [31:0] cap_word;
  logic [31:0] byte_addr;
  logic [2:0]  lsb_bytes;

  function automatic logic is_io(input logic [31:0] a);
    return (a & IO_ADDR) == IO_ADDR;
  endfunction

  // Byte k-1 arrives on mem_din while k counts the edges spent in READ.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign cap_word[8*gi +: 8] = (k_reg == 3'(gi + 1)) ? mem_din : buf_reg[8*gi +: 8];
  end

  assign byte_addr = addr_reg + {29'd0, k_reg};

  always_comb begin
    case (lsb_data_width)
      2'd0:    lsb_bytes = 3'd1;
      2'd1:    lsb_bytes = 3'd2;
      default: lsb_bytes = 3'd4;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg          <= IDLE;
      owner_reg          <= OWN_LSB;
      n_reg              <= 3'd0;
      k_reg              <= 3'd0;
      addr_reg           <= 32'd0;
      data_reg           <= 32'd0;
      buf_reg            <= 32'd0;
      mem_a_reg          <= 32'd0;
      mem_dout_reg       <= 8'd0;
      mem_wr_reg         <= 1'b0;
      lsb_reply_en_reg   <= 1'b0;
      lsb_reply_data_reg <= 32'd0;
      ic_reply_en_reg    <= 1'b0;
      ic_reply_data_reg  <= 32'd0;
    end else if (rdy_in) begin
      state_reg          <= state_next;
      owner_reg          <= owner_next;
      n_reg              <= n_next;
      k_reg              <= k_next;
      addr_reg           <= addr_next;
      data_reg           <= data_next;
      buf_reg            <= buf_next;
      mem_a_reg          <= mem_a_next;
      mem_dout_reg       <= mem_dout_next;
      mem_wr_reg         <= mem_wr_next;
      lsb_reply_en_reg   <= lsb_reply_en_next;
      lsb_reply_data_reg <= lsb_reply_data_next;
      ic_reply_en_reg    <= ic_reply_en_next;
      ic_reply_data_reg  <= ic_reply_data_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    owner_next          = owner_reg;
    n_next              = n_reg;
    k_next              = k_reg;
    addr_next           = addr_reg;
    data_next           = data_reg;
    buf_next            = buf_reg;
    mem_a_next          = mem_a_reg;
    mem_dout_next       = mem_dout_reg;
    mem_wr_next         = mem_wr_reg;
    lsb_reply_en_next   = 1'b0;
    lsb_reply_data_next = lsb_reply_data_reg;
    ic_reply_en_next    = 1'b0;
    ic_reply_data_next  = ic_reply_data_reg;

    case (state_reg)
      IDLE: begin
        if (!flush_signal && lsb_query_en) begin
          owner_next = OWN_LSB;
          addr_next  = lsb_query_addr;
          data_next  = lsb_query_data;
          n_next     = lsb_bytes;
          buf_next   = 32'd0;
          if (lsb_query_type) begin
            state_next = WRITE;
            // First byte goes out on the accept edge unless the IO buffer blocks it.
            if (is_io(lsb_query_addr) && io_buffer_full) begin
              k_next      = 3'd0;
              mem_wr_next = 1'b0;
            end else begin
              mem_a_next    = lsb_query_addr;
              mem_dout_next = lsb_query_data[7:0];
              mem_wr_next   = 1'b1;
              k_next        = 3'd1;
            end
          end else begin
            state_next  = READ;
            mem_a_next  = lsb_query_addr;
            mem_wr_next = 1'b0;
            k_next      = 3'd0;
          end
        end else if (!flush_signal && ic_query_en) begin
          owner_next  = OWN_IC;
          addr_next   = ic_query_addr;
          n_next      = 3'd4;
          buf_next    = 32'd0;
          state_next  = READ;
          mem_a_next  = ic_query_addr;
          mem_wr_next = 1'b0;
          k_next      = 3'd0;
        end
      end

      READ: begin
        buf_next = cap_word;
        if (flush_signal) begin
          state_next = IDLE;
          mem_a_next = 32'd0;
        end else if (k_reg == n_reg) begin
          state_next = COOL;
          mem_a_next = 32'd0;
          if (owner_reg == OWN_IC) begin
            ic_reply_en_next   = 1'b1;
            ic_reply_data_next = cap_word;
          end else begin
            lsb_reply_en_next   = 1'b1;
            lsb_reply_data_next = cap_word;
          end
        end else begin
          if (k_reg + 3'd1 < n_reg)
            mem_a_next = addr_reg + {29'd0, k_reg + 3'd1};
          k_next = k_reg + 3'd1;
        end
      end

      WRITE: begin
        if (k_reg == n_reg) begin
          state_next          = COOL;
          mem_wr_next         = 1'b0;
          mem_a_next          = 32'd0;
          lsb_reply_en_next   = 1'b1;
          lsb_reply_data_next = data_reg;
        end else if (is_io(byte_addr) && io_buffer_full) begin
          mem_wr_next = 1'b0;
        end else begin
          mem_a_next    = byte_addr;
          mem_dout_next = data_reg[{k_reg[1:0], 3'b000} +: 8];
          mem_wr_next   = 1'b1;
          k_next        = k_reg + 3'd1;
        end
      end

      // Requesters still hold query_en during this cycle; ignore them.
      COOL: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign mem_a          = mem_a_reg;
  assign mem_dout       = mem_dout_reg;
  assign mem_wr         = mem_wr_reg;
  assign lsb_reply_en   = lsb_reply_en_reg;
  assign lsb_reply_data = lsb_reply_data_reg;
  assign ic_reply_en    = ic_reply_en_reg;
  assign ic_reply_data  = ic_reply_data_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, table of clean transactions plus
// hand-written arbitration, IO stall, flush, reset and ready-freeze sequences.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        flush_signal = 1'b0;
  logic        lsb_query_en = 1'b0;
  logic        lsb_query_type = 1'b0;
  logic [31:0] lsb_query_addr = 32'd0;
  logic [1:0]  lsb_data_width = 2'd0;
  logic [31:0] lsb_query_data = 32'd0;
  logic        lsb_reply_en;
  logic [31:0] lsb_reply_data;
  logic        ic_query_en = 1'b0;
  logic [31:0] ic_query_addr = 32'd0;
  logic        ic_reply_en;
  logic [31:0] ic_reply_data;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
    .lsb_query_en(lsb_query_en), .lsb_query_type(lsb_query_type),
    .lsb_query_addr(lsb_query_addr), .lsb_data_width(lsb_data_width),
    .lsb_query_data(lsb_query_data), .lsb_reply_en(lsb_reply_en),
    .lsb_reply_data(lsb_reply_data), .ic_query_en(ic_query_en),
    .ic_query_addr(ic_query_addr), .ic_reply_en(ic_reply_en),
    .ic_reply_data(ic_reply_data), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          is_ic;
    bit          wr;
    logic [1:0]  w;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    bit          is_ic;
    logic [31:0] data;
    int          ecyc;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   wr_cyc = 0;
  int   io_cnt = 0;
  logic [7:0] io_last = 8'd0;
  logic [7:0] ram [0:65535];

  // RAM: registered read of the current address, write when mem_wr is high.
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      if (mem_a == 32'h0003_0000) begin
        io_cnt  <= io_cnt + 1;
        io_last <= mem_dout;
      end
    end
  end

  always @(negedge clk_in) if (mem_wr) wr_cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: timed out waiting for reply (cycle %0d)", name, cyc);
  endfunction

  // Scoreboard: every reply pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (!rst_in && (lsb_reply_en || ic_reply_en)) begin
      if (sb_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_reply: lsb=%0b ic=%0b at cycle %0d, none expected",
                 lsb_reply_en, ic_reply_en, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("reply %s data=%h cycle=%0d", ic_reply_en ? "ic " : "lsb",
                 ic_reply_en ? ic_reply_data : lsb_reply_data, cyc);
        chk("reply_owner", {31'd0, ic_reply_en}, {31'd0, e.is_ic});
        chk("reply_data", ic_reply_en ? ic_reply_data : lsb_reply_data, e.data);
        chk("reply_cycle", cyc, e.ecyc);
      end
    end
  end

  task automatic wait_rep(input bit is_ic, input string tag);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_in);
      if (is_ic ? ic_reply_en : lsb_reply_en) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now(tag);
  endtask

  // Clean transaction: checks the per-byte bus sequence and reply latency.
  task automatic do_req(input vec_t v);
    int          n;
    int          wr0;
    bit          got;
    logic [31:0] sh;
    exp_t        e;
    n = v.is_ic ? 4 : (v.w == 2'd0 ? 1 : (v.w == 2'd1 ? 2 : 4));
    @(negedge clk_in);
    wr0 = wr_cyc;
    e.is_ic = v.is_ic;
    e.data  = v.exp_data;
    e.ecyc  = cyc + 1 + v.lat;
    sb_q.push_back(e);
    $display("txn %s %s w=%0d addr=%h wdata=%h", v.is_ic ? "ic " : "lsb",
             v.wr ? "wr" : "rd", v.w, v.addr, v.wdata);
    if (v.is_ic) begin
      ic_query_en   = 1'b1;
      ic_query_addr = v.addr;
    end else begin
      lsb_query_en   = 1'b1;
      lsb_query_type = v.wr;
      lsb_query_addr = v.addr;
      lsb_data_width = v.w;
      lsb_query_data = v.wdata;
    end
    got = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_in);
      if (c <= n) begin
        chk("addr_seq", mem_a, v.addr + 32'(c - 1));
        if (v.wr) begin
          sh = v.wdata >> (8 * (c - 1));
          chk("dout_seq", {24'd0, mem_dout}, {24'd0, sh[7:0]});
        end
      end
      if (v.is_ic ? ic_reply_en : lsb_reply_en) begin
        got = 1'b1;
        chk("addr_after_reply", mem_a, 32'd0);
        break;
      end
    end
    if (!got) fail_now("txn_reply");
    @(posedge clk_in);
    #1;
    lsb_query_en = 1'b0;
    ic_query_en  = 1'b0;
    chk("wr_cycles", wr_cyc - wr0, v.wr ? n : 0);
  endtask

  vec_t vecs[14];

  initial begin
    int   c0;
    exp_t e;

    vecs[0]  = '{1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0,          5, 32'h4433_2211};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'h0000_2002, 32'h0000_BEEF,  2, 32'h0000_BEEF};
    vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h0000_2002, 32'h0,          3, 32'h0000_BEEF};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 32'h0000_1003, 32'h0,          2, 32'h0000_0044};
    vecs[4]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0,          5, 32'h4433_2211};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 32'h0000_3001, 32'hCAFE_F00D,  4, 32'hCAFE_F00D};
    vecs[6]  = '{1'b0, 1'b0, 2'd2, 32'h0000_3001, 32'h0,          5, 32'hCAFE_F00D};
    vecs[7]  = '{1'b0, 1'b0, 2'd3, 32'h0000_3002, 32'h0,          5, 32'h00CA_FEF0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_4000, 32'h1234_5677,  1, 32'h1234_5677};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 32'h0000_3FFF, 32'h0,          3, 32'h0000_779C};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_A5C3,  2, 32'h0000_A5C3};
    vecs[11] = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,          3, 32'h0000_A5C3};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 32'h0000_3001, 32'h0,          5, 32'hCAFE_F00D};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 32'h0,          2, 32'h0000_00A5};

    for (int i = 0; i < 65536; i++) ram[i] <= 8'd0;
    #1;
    ram[16'h1000] <= 8'h11;
    ram[16'h1001] <= 8'h22;
    ram[16'h1002] <= 8'h33;
    ram[16'h1003] <= 8'h44;
    ram[16'h3FFF] <= 8'h9C;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_lsb_reply_en", {31'd0, lsb_reply_en}, 32'd0);
    chk("rst_ic_reply_en", {31'd0, ic_reply_en}, 32'd0);
    chk("rst_lsb_reply_data", lsb_reply_data, 32'd0);
    chk("rst_ic_reply_data", ic_reply_data, 32'd0);

    for (int i = 0; i < 14; i++) do_req(vecs[i]);
    chk("ram_sh_lo", {24'd0, ram[16'h2002]}, 32'h0000_00EF);
    chk("ram_sh_hi", {24'd0, ram[16'h2003]}, 32'h0000_00BE);

    // LSB and IC on the same edge: LSB first, IC accepted after COOL.
    @(negedge clk_in);
    c0 = cyc;
    $display("txn lsb rd + ic fetch simultaneous");
    lsb_query_en = 1'b1; lsb_query_type = 1'b0; lsb_data_width = 2'd0;
    lsb_query_addr = 32'h0000_1001;
    ic_query_en = 1'b1; ic_query_addr = 32'h0000_1000;
    e = '{1'b0, 32'h0000_0022, c0 + 3};   sb_q.push_back(e);
    e = '{1'b1, 32'h4433_2211, c0 + 10};  sb_q.push_back(e);
    wait_rep(1'b0, "prio_lsb");
    @(posedge clk_in); #1; lsb_query_en = 1'b0;
    wait_rep(1'b1, "prio_ic");
    @(posedge clk_in); #1; ic_query_en = 1'b0;

    // IO byte store held off by io_buffer_full for three edges.
    @(negedge clk_in);
    c0 = cyc;
    $display("txn lsb wr io 0x30000 with buffer full");
    io_buffer_full = 1'b1;
    lsb_query_en = 1'b1; lsb_query_type = 1'b1; lsb_data_width = 2'd0;
    lsb_query_addr = 32'h0003_0000; lsb_query_data = 32'h0000_0041;
    e = '{1'b0, 32'h0000_0041, c0 + 5};  sb_q.push_back(e);
    begin
      int io0;
      io0 = io_cnt;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk_in);
        chk("io_stall_wr", {31'd0, mem_wr}, 32'd0);
      end
      io_buffer_full = 1'b0;
      wait_rep(1'b0, "io_reply");
      @(posedge clk_in); #1; lsb_query_en = 1'b0;
      chk("io_write_count", io_cnt - io0, 32'd1);
      chk("io_write_byte", {24'd0, io_last}, 32'h0000_0041);
    end

    // Flush on the third READ edge aborts the fetch; the held request restarts.
    @(negedge clk_in);
    c0 = cyc;
    $display("txn ic fetch with flush");
    ic_query_en = 1'b1; ic_query_addr = 32'h0000_1000;
    repeat (3) @(posedge clk_in);
    #1 flush_signal = 1'b1;
    @(posedge clk_in);
    #1 flush_signal = 1'b0;
    @(negedge clk_in);
    chk("flush_mem_a", mem_a, 32'd0);
    chk("flush_no_reply", {31'd0, ic_reply_en}, 32'd0);
    e = '{1'b1, 32'h4433_2211, c0 + 10};  sb_q.push_back(e);
    @(negedge clk_in);
    chk("flush_reaccept", mem_a, 32'h0000_1000);
    wait_rep(1'b1, "flush_refetch");
    @(posedge clk_in); #1; ic_query_en = 1'b0;

    // Flush while idle delays acceptance by one edge.
    @(negedge clk_in);
    c0 = cyc;
    $display("txn lsb rd with idle flush");
    flush_signal = 1'b1;
    lsb_query_en = 1'b1; lsb_query_type = 1'b0; lsb_data_width = 2'd0;
    lsb_query_addr = 32'h0000_1000;
    e = '{1'b0, 32'h0000_0011, c0 + 4};  sb_q.push_back(e);
    @(posedge clk_in);
    #1 flush_signal = 1'b0;
    wait_rep(1'b0, "idle_flush");
    @(posedge clk_in); #1; lsb_query_en = 1'b0;

    // Reset in the middle of a word store.
    @(negedge clk_in);
    $display("txn lsb wr word interrupted by reset");
    lsb_query_en = 1'b1; lsb_query_type = 1'b1; lsb_data_width = 2'd2;
    lsb_query_addr = 32'h0000_5000; lsb_query_data = 32'h0102_0304;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    lsb_query_en = 1'b0;
    @(negedge clk_in);
    chk("midrst_mem_a", mem_a, 32'd0);
    chk("midrst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("midrst_lsb_reply_en", {31'd0, lsb_reply_en}, 32'd0);
    chk("midrst_lsb_reply_data", lsb_reply_data, 32'd0);
    chk("midrst_ic_reply_data", ic_reply_data, 32'd0);
    do_req(vecs[3]);

    // rdy_in low for two edges right after acceptance of a word read.
    @(negedge clk_in);
    c0 = cyc;
    $display("txn lsb rd word with rdy low");
    lsb_query_en = 1'b1; lsb_query_type = 1'b0; lsb_data_width = 2'd2;
    lsb_query_addr = 32'h0000_1000;
    e = '{1'b0, 32'h4433_2211, c0 + 8};  sb_q.push_back(e);
    @(posedge clk_in);
    #1 rdy_in = 1'b0;
    @(negedge clk_in);
    chk("rdy_hold_a0", mem_a, 32'h0000_1000);
    @(posedge clk_in);
    @(negedge clk_in);
    chk("rdy_hold_a1", mem_a, 32'h0000_1000);
    @(posedge clk_in);
    #1 rdy_in = 1'b1;
    wait_rep(1'b0, "rdy_reply");
    @(posedge clk_in); #1; lsb_query_en = 1'b0;

    repeat (4) @(negedge clk_in);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
